// File: rtl/io_bus_pkg.sv
// Shared types and constants for the MMIO device-bus master.
package io_bus_pkg;

    // Default width of the address, data and request buses.
    localparam int DEFAULT_BITS = 32;

    // Address parked on ABUS between bus cycles; no device decodes it.
    localparam logic [DEFAULT_BITS-1:0] IDLE_ADDR = '0;

    // Bus-cycle phases of the master.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // no bus cycle, ABUS parked
        WRITE     = 2'd1,  // write data on DBUS, WE high
        RD_TURN   = 2'd2,  // bus turnaround, device starts driving
        RD_SAMPLE = 2'd3   // read data settling, sampled on exit
    } bus_state_e;

endpackage

// File: rtl/io_bus_master.sv
// MMIO bus master: turns memory-stage requests into device bus cycles.
// Writes take one WRITE cycle and can stream back to back. Reads take a
// turnaround cycle and a sample cycle, then return one rsp_valid pulse.
// FLUSH aborts reads and drops new requests. RESET overrides everything.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int              BITS      = io_bus_pkg::DEFAULT_BITS,
    parameter logic [BITS-1:0] IDLE_ADDR = io_bus_pkg::IDLE_ADDR
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [BITS-1:0] req_addr,
    input  logic [BITS-1:0] req_wdata,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [BITS-1:0] rsp_rdata,
    output logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    output logic            WE
);

    bus_state_e      state;
    logic [BITS-1:0] wdata_q;
    logic            accept;

    // Requests are taken only when no read is in flight, never during a
    // flush (dropped, not queued) and never while reset is asserted.
    // NOTE: req_ready is combinational on FLUSH/RESET, so a request presented
    // in the same cycle as either is refused, not remembered for later.
    assign req_ready = ((state == IDLE) || (state == WRITE)) && !FLUSH && !RESET;
    assign accept    = req_valid && req_ready;

    // The master drives DBUS only in WRITE. WE is registered to be high
    // exactly in WRITE, so the bus is never driven while WE is low.
    assign DBUS = (state == WRITE) ? wdata_q : {BITS{1'bz}};

    // Bus-cycle FSM with registered bus outputs and read response.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, e.g. rsp_rdata samples
    // DBUS as the device drove it during RD_SAMPLE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ABUS      <= IDLE_ADDR;
            WE        <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // The response is a single-cycle pulse.
            rsp_valid <= 1'b0;

            unique case (state)
                // IDLE and WRITE share acceptance so writes can stream with
                // no IDLE gap and a read can follow a write directly.
                IDLE, WRITE: begin
                    if (accept) begin
                        ABUS    <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_we) begin
                            state <= WRITE;
                            WE    <= 1'b1;
                        end else begin
                            // WE drops in the same cycle DBUS is released.
                            state <= RD_TURN;
                            WE    <= 1'b0;
                        end
                    end else begin
                        // A flushed WRITE simply ends; the devices have
                        // already suppressed it and there is no retry.
                        state <= IDLE;
                        ABUS  <= IDLE_ADDR;
                        WE    <= 1'b0;
                    end
                end

                RD_TURN: begin
                    if (FLUSH) begin
                        state <= IDLE;
                        ABUS  <= IDLE_ADDR;
                    end else begin
                        // ABUS held so the device keeps driving its data.
                        state <= RD_SAMPLE;
                    end
                end

                RD_SAMPLE: begin
                    // An aborted read leaves the previous response intact.
                    if (!FLUSH) begin
                        rsp_rdata <= DBUS;
                        rsp_valid <= 1'b1;
                    end
                    state <= IDLE;
                    ABUS  <= IDLE_ADDR;
                end

                default: begin
                    state <= IDLE;
                    ABUS  <= IDLE_ADDR;
                    WE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_io_bus_master;

    localparam int          BITS       = 32;
    localparam logic [31:0] BASE       = 32'h0000_1000;
    localparam logic [31:0] BACKGROUND = 32'h5A5A_A5A5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] ABUS;
    wire  [31:0] DBUS;
    logic        WE;

    io_bus_master #(.BITS(BITS), .IDLE_ADDR(32'h0)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ABUS      (ABUS),
        .DBUS      (DBUS),
        .WE        (WE)
    );

    always #5 CLK = ~CLK;

    // Device model: a 16-word register file at BASE. While WE is low the
    // bench side drives DBUS (register data when addressed, a fixed pattern
    // otherwise), so any master drive while WE=0 corrupts the bus value.
    logic [31:0] dev_mem [16];
    logic [31:0] dev_val;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    always_comb begin
        dev_val = BACKGROUND;
        if (in_range(ABUS)) dev_val = dev_mem[ABUS[3:0]];
    end

    assign DBUS = WE ? {32{1'bz}} : dev_val;

    always @(posedge CLK) begin
        if (WE && !FLUSH && in_range(ABUS)) dev_mem[ABUS[3:0]] <= DBUS;
    end

    // Reference model: expected bus contents and the age of any read.
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_mem [16];
    int          rd_age;          // 0: no read, 1: turnaround, 2: sampling
    logic        exp_we;
    logic [31:0] exp_abus;
    logic [31:0] exp_wdata;
    logic        exp_rsp_valid;
    logic [31:0] exp_rsp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_bus();
        if (exp_we) return exp_wdata;
        if (in_range(exp_abus)) return exp_mem[exp_abus[3:0]];
        return BACKGROUND;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational ready, advance the model at the rising edge, then
    // check every registered output on the next falling edge.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic fl, input logic rs);
        logic acc;
        logic [31:0] bus_now;
        req_valid = v; req_we = w; req_addr = a; req_wdata = d;
        FLUSH = fl; RESET = rs;
        #1;
        check("req_ready", {31'b0, req_ready}, {31'b0, (rd_age == 0) && !fl && !rs});
        acc = v && (rd_age == 0) && !fl && !rs;
        bus_now = exp_bus();
        @(posedge CLK);
        // A write on the bus lands in the device unless flushed.
        if (exp_we && !fl && in_range(exp_abus)) exp_mem[exp_abus[3:0]] = exp_wdata;
        if (rs) begin
            rd_age = 0; exp_we = 0; exp_abus = '0; exp_wdata = '0;
            exp_rsp_valid = 0; exp_rsp_rdata = '0;
        end else begin
            exp_rsp_valid = 0;
            if (rd_age == 2 && !fl) begin
                exp_rsp_valid = 1;
                exp_rsp_rdata = bus_now;
            end
            if (acc) begin
                exp_abus = a; exp_wdata = d; exp_we = w;
                rd_age = w ? 0 : 1;
            end else if (rd_age == 1 && !fl) begin
                rd_age = 2;
            end else begin
                rd_age = 0; exp_we = 0; exp_abus = '0;
            end
        end
        @(negedge CLK);
        check("WE", {31'b0, WE}, {31'b0, exp_we});
        check("ABUS", ABUS, exp_abus);
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_valid});
        check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
        check("DBUS", DBUS, exp_bus());
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = '0;
            exp_mem[i] = '0;
        end
        rd_age = 0; exp_we = 0; exp_abus = '0; exp_wdata = '0;
        exp_rsp_valid = 0; exp_rsp_rdata = '0;
        @(negedge CLK);

        // Reset state.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, BASE, 32'hFFFF, 1'b0, 1'b1);
        check("reset_we", {31'b0, WE}, 32'd0);
        check("reset_abus", ABUS, 32'd0);
        check("reset_rsp", rsp_rdata, 32'd0);

        // Single write then idle: one WE cycle, device holds 1234.
        step(1'b1, 1'b1, BASE, 32'h1234, 1'b0, 1'b0);
        check("wr_we_high", {31'b0, WE}, 32'd1);
        idle_cycle();
        check("wr_we_low", {31'b0, WE}, 32'd0);
        check("wr_abus_idle", ABUS, 32'd0);
        check("wr_device", dev_mem[0], 32'h1234);

        // Three back-to-back writes to one register.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, BASE + 32'd1, i, 1'b0, 1'b0);
            check("b2b_we", {31'b0, WE}, 32'd1);
        end
        idle_cycle();
        check("b2b_device", dev_mem[1], 32'd3);

        // Write CAFE, then read it directly after (write-to-read turnaround).
        step(1'b1, 1'b1, BASE + 32'd4, 32'hCAFE, 1'b0, 1'b0);
        step(1'b1, 1'b0, BASE + 32'd4, '0, 1'b0, 1'b0);
        check("turn_we_low", {31'b0, WE}, 32'd0);
        idle_cycle();
        check("rd_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
        idle_cycle();
        check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rd_rsp_data", rsp_rdata, 32'hCAFE);
        idle_cycle();
        check("rd_pulse_end", {31'b0, rsp_valid}, 32'd0);

        // Read aborted by FLUSH in RD_TURN, then a clean read.
        step(1'b1, 1'b0, BASE + 32'd1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, BASE + 32'd2, 32'h77, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("flush_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        check("flush_rdata_kept", rsp_rdata, 32'hCAFE);
        check("flush_dropped_wr", dev_mem[2], 32'd0);
        step(1'b1, 1'b0, BASE + 32'd1, '0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check("post_flush_rsp", rsp_rdata, 32'd3);

        // Reset during WRITE and during RD_SAMPLE.
        step(1'b1, 1'b1, BASE + 32'd5, 32'hBEEF, 1'b0, 1'b0);
        step(1'b1, 1'b1, BASE + 32'd6, 32'h1, 1'b0, 1'b1);
        check("rst_wr_we", {31'b0, WE}, 32'd0);
        check("rst_wr_abus", ABUS, 32'd0);
        step(1'b1, 1'b0, BASE + 32'd4, '0, 1'b0, 1'b0);
        idle_cycle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_rd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rd_rsp_rdata", rsp_rdata, 32'd0);
        idle_cycle();
        check("rst_rd_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000 | $urandom_range(1, 255);
            else a = BASE | $urandom_range(0, 15);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
